// File: rtl/mac_pipe_acc.sv
// Two-stage pipelined unsigned multiply-add (MAD) / multiply-accumulate (ACC) unit; optional MAC_PIPE_SAT_EN clamps ACC overflow.
// Latency: 2 clk in_valid -> out_valid, one operation per clock.
// Backpressure: none; every out_valid pulse must be consumed by the downstream block.
module mac_pipe_acc #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [ACC_W-1:0] data_out,
    output logic             ovf
);

    localparam int PW = 2*WIDTH;

    if (ACC_W < 2*WIDTH+1) begin : g_acc_w_chk
        $error("mac_pipe_acc: ACC_W must be >= 2*WIDTH+1");
    end

    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             mode_q, mode_d;
    logic             clr_q, clr_d;
    logic             v1_q;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             ov_q;

    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic             acc_carry;
    logic [ACC_W-1:0] acc_res;
    logic [ACC_W-1:0] mad_res;

    always_comb begin
        prod_d = prod_q;
        c_d    = c_q;
        mode_d = mode_q;
        clr_d  = clr_q;
        if (in_valid) begin
            prod_d = PW'(a) * PW'(b);
            c_d    = c;
            mode_d = mode;
            clr_d  = acc_clr;
        end
    end

    // One spare top bit on the ACC adder exposes the carry used for ovf.
    assign acc_base  = clr_q ? '0 : acc_q;
    assign acc_sum   = {1'b0, acc_base} + (ACC_W+1)'(prod_q);
    assign acc_carry = acc_sum[ACC_W];
    assign mad_res   = ACC_W'(prod_q) + ACC_W'(c_q);

`ifdef MAC_PIPE_SAT_EN
    assign acc_res = acc_carry ? '1 : acc_sum[ACC_W-1:0];
`else
    assign acc_res = acc_sum[ACC_W-1:0];
`endif

    always_comb begin
        acc_d  = acc_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (v1_q) begin
            if (!mode_q) begin
                data_d = mad_res;
            end else begin
                acc_d  = acc_res;
                data_d = acc_res;
                ovf_d  = (clr_q ? 1'b0 : ovf_q) | acc_carry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            c_q    <= '0;
            mode_q <= 1'b0;
            clr_q  <= 1'b0;
            v1_q   <= 1'b0;
            acc_q  <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            c_q    <= c_d;
            mode_q <= mode_d;
            clr_q  <= clr_d;
            v1_q   <= in_valid;
            acc_q  <= acc_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            ov_q   <= v1_q;
        end
    end

    assign out_valid = ov_q;
    assign data_out  = data_q;
    assign ovf       = ovf_q;

endmodule
